// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, funct
// codes, ALU control codes, mux select codes and FSM state encodings.
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_RALT  = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_DIV = 6'b111111;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_DIV = 3'b011;

  // ALU B operand select
  localparam logic [1:0] ALUB_B      = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Writeback select
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_DIV    = 2'b10;

  // FSM state encodings
  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMRD    = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWR    = 4'd6;
  localparam logic [3:0] S_RTYPE_EX = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_DIV_REQ  = 4'd13;
  localparam logic [3:0] S_DIV_WAIT = 4'd14;
  localparam logic [3:0] S_DIV_WB   = 4'd15;

endpackage

// File: rtl/multicycle_ctrl_alu_funct_dec.sv
// R-type funct decoder: maps funct to an ALU control code and flags whether
// the funct is one of the supported register-register operations.
module alu_funct_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  // Translate funct into ALU operation; unsupported codes fall back to add
  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    case (funct)
      FN_ADD: begin alu_control = ALU_ADD; legal = 1'b1; end
      FN_SUB: begin alu_control = ALU_SUB; legal = 1'b1; end
      FN_AND: begin alu_control = ALU_AND; legal = 1'b1; end
      FN_OR:  begin alu_control = ALU_OR;  legal = 1'b1; end
      FN_SLT: begin alu_control = ALU_SLT; legal = 1'b1; end
      default: begin alu_control = ALU_ADD; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multi-cycle MIPS datapath. Outputs are a
// pure decode of the state register (plus zero, mem_ready, funct, div_done
// where noted), so an asynchronous reset to INIT clears every strobe at once.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = $clog2(DIV_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       div_done,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       div_start,
  output logic       illegal_op,
  output logic       div_timeout,
  output logic [3:0] state_o
);

  logic [3:0]       state;
  logic [3:0]       next_state;
  logic [3:0]       decode_next;
  logic             decode_illegal;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  logic [2:0]       dec_alu_control;
  logic             dec_legal;

  alu_funct_dec u_funct_dec (
    .funct       (funct),
    .alu_control (dec_alu_control),
    .legal       (dec_legal)
  );

  // Last permitted DIV_WAIT cycle: counter started at 0 on entry
  assign timeout_hit = (cnt == CNT_W'(DIV_TIMEOUT - 1));
  assign state_o     = state;

  // State register and divider wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= {CNT_W{1'b0}};
    end else begin
      state <= next_state;
      if (state == S_DIV_REQ) begin
        cnt <= {CNT_W{1'b0}};
      end else if (state == S_DIV_WAIT) begin
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt <= cnt;
      end
    end
  end

  // Instruction dispatch from DECODE, including legality of op/funct
  always_comb begin
    decode_next    = S_FETCH;
    decode_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (dec_legal) decode_next = S_RTYPE_EX;
        else           decode_illegal = 1'b1;
      end
      OP_RALT: begin
        if (funct == FN_DIV)  decode_next = S_DIV_REQ;
        else if (dec_legal)   decode_next = S_RTYPE_EX;
        else                  decode_illegal = 1'b1;
      end
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_ADDI:      decode_next = S_ADDI_EX;
      OP_BEQ:       decode_next = S_BEQ;
      OP_J:         decode_next = S_JUMP;
      default:      decode_illegal = 1'b1;
    endcase
  end

  // Next-state selection
  always_comb begin
    next_state = S_INIT;
    case (state)
      S_INIT:     next_state = S_FETCH;
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   next_state = decode_next;
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: next_state = S_ALU_WB;
      S_ALU_WB:   next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_ADDI_EX:  next_state = S_ADDI_WB;
      S_ADDI_WB:  next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_DIV_REQ:  next_state = S_DIV_WAIT;
      S_DIV_WAIT: begin
        // A completing divide beats a simultaneous timeout
        if (div_done)         next_state = S_DIV_WB;
        else if (timeout_hit) next_state = S_FETCH;
        else                  next_state = S_DIV_WAIT;
      end
      S_DIV_WB:   next_state = S_FETCH;
      default:    next_state = S_INIT;
    endcase
  end

  // Control output decode
  always_comb begin
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = WB_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = ALUB_B;
    pc_src      = PCS_ALU;
    alu_control = ALU_ADD;
    div_start   = 1'b0;
    illegal_op  = 1'b0;
    div_timeout = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = ALUB_IMM_SH;
        illegal_op = decode_illegal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a   = 1'b1;
        alu_control = dec_alu_control;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCS_ALUOUT;
        pc_en       = zero;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PCS_JUMP;
        pc_en  = 1'b1;
      end
      S_DIV_REQ: begin
        div_start   = 1'b1;
        alu_src_a   = 1'b1;
        alu_control = ALU_DIV;
      end
      S_DIV_WAIT: div_timeout = !div_done && timeout_hit;
      S_DIV_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = WB_DIV;
      end
      default: illegal_op = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Inputs change just after a falling edge
// and outputs are sampled on falling edges (or 1 ns after an input change).
module tb_multicycle_ctrl;

  logic       clk, rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready, div_done;
  logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst;
  logic [1:0] mem_to_reg, alu_src_b, pc_src;
  logic       alu_src_a, div_start, illegal_op, div_timeout;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic [15:0] strobes;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.DIV_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .div_done(div_done), .pc_en(pc_en), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .div_start(div_start), .illegal_op(illegal_op),
    .div_timeout(div_timeout), .state_o(state_o)
  );

  assign strobes = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, pc_src, div_start, illegal_op, div_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory write and register write must never coincide
  always @(negedge clk) begin
    checks++;
    if (mem_write === 1'b1 && reg_write === 1'b1) begin
      errors++; $display("FAIL wr_exclusive: mem_write=%b reg_write=%b want not both 1", mem_write, reg_write);
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0; div_done = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (strobes !== 16'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", strobes); end
    checks++; if (alu_control !== 3'b010) begin errors++; $display("FAIL reset_alu: got %b want 010", alu_control); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL init_to_fetch: got %0d want 1", state_o); end
    checks++; if (ir_write !== 1'b0 || pc_en !== 1'b0) begin
      errors++; $display("FAIL fetch_wait: ir_write=%b pc_en=%b want 0 0", ir_write, pc_en); end
  endtask

  task automatic test_lw();
    int seq[6] = '{1, 2, 3, 4, 5, 1};
    logic exp_rw, exp_f;
    op = 6'b100011; funct = 6'd0; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) #1; else @(negedge clk);
      exp_rw = (seq[i] == 5);
      exp_f  = (seq[i] == 1);
      checks++; if (state_o !== 4'(seq[i])) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, seq[i]); end
      checks++; if (reg_write !== exp_rw || (exp_rw && mem_to_reg !== 2'b01)) begin
        errors++; $display("FAIL lw_regwrite[%0d]: reg_write=%b mem_to_reg=%b want %b 01", i, reg_write, mem_to_reg, exp_rw); end
      checks++; if (ir_write !== exp_f || pc_en !== exp_f) begin
        errors++; $display("FAIL lw_fetch[%0d]: ir_write=%b pc_en=%b want %b", i, ir_write, pc_en, exp_f); end
      if (seq[i] == 4) begin
        checks++; if (iord !== 1'b1) begin errors++; $display("FAIL lw_iord: got %b want 1", iord); end
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_sw();
    op = 6'b101011; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== 4'd2) begin errors++; $display("FAIL sw_decode: got %0d want 2", state_o); end
    @(negedge clk);
    checks++; if (state_o !== 4'd3 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin
      errors++; $display("FAIL sw_memadr: state=%0d alu_src_b=%b want 3 10", state_o, alu_src_b); end
    mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (state_o !== 4'd6 || mem_write !== 1'b1 || iord !== 1'b1 || reg_write !== 1'b0) begin
        errors++; $display("FAIL sw_memwr[%0d]: state=%0d mem_write=%b reg_write=%b want 6 1 0", k, state_o, mem_write, reg_write); end
      if (k == 4) mem_ready = 1'b1;
    end
    @(negedge clk);
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL sw_done: got %0d want 1", state_o); end
    mem_ready = 1'b0;
  endtask

  task automatic test_beq();
    op = 6'b000100; zero = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 4'd9 || pc_en !== 1'b1 || pc_src !== 2'b01 || alu_control !== 3'b110) begin
      errors++; $display("FAIL beq_taken: state=%0d pc_en=%b pc_src=%b alu=%b want 9 1 01 110", state_o, pc_en, pc_src, alu_control); end
    zero = 1'b0;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL beq_not_taken: pc_en=%b want 0", pc_en); end
    @(negedge clk);
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL beq_return: got %0d want 1", state_o); end
  endtask

  task automatic test_rtype();
    logic [5:0] ops[2] = '{6'b000000, 6'b001001};
    logic [5:0] fns[2] = '{6'b101010, 6'b100010};
    logic [2:0] alus[2] = '{3'b111, 3'b110};
    for (int v = 0; v < 2; v++) begin
      op = ops[v]; funct = fns[v]; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      checks++; if (state_o !== 4'd7 || alu_control !== alus[v] || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
        errors++; $display("FAIL rtype_ex[%0d]: state=%0d alu=%b want 7 %b", v, state_o, alu_control, alus[v]); end
      @(negedge clk);
      checks++; if (state_o !== 4'd8 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 2'b00) begin
        errors++; $display("FAIL rtype_wb[%0d]: state=%0d reg_write=%b reg_dst=%b want 8 1 1", v, state_o, reg_write, reg_dst); end
      @(negedge clk);
      checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL rtype_return[%0d]: got %0d want 1", v, state_o); end
    end
  endtask

  task automatic test_div_done();
    int starts = 0;
    op = 6'b001001; funct = 6'b111111; mem_ready = 1'b1;
    @(negedge clk);
    starts += int'(div_start);
    checks++; if (state_o !== 4'd2) begin errors++; $display("FAIL div_decode: got %0d want 2", state_o); end
    mem_ready = 1'b0;
    @(negedge clk);
    starts += int'(div_start);
    checks++; if (state_o !== 4'd13 || alu_control !== 3'b011) begin
      errors++; $display("FAIL div_req: state=%0d alu=%b want 13 011", state_o, alu_control); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      starts += int'(div_start);
      checks++; if (state_o !== 4'd14 || div_timeout !== 1'b0) begin
        errors++; $display("FAIL div_wait[%0d]: state=%0d div_timeout=%b want 14 0", k, state_o, div_timeout); end
    end
    div_done = 1'b1;
    @(negedge clk);
    starts += int'(div_start);
    div_done = 1'b0;
    checks++; if (state_o !== 4'd15 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 2'b10) begin
      errors++; $display("FAIL div_wb: state=%0d reg_write=%b reg_dst=%b mem_to_reg=%b want 15 1 1 10", state_o, reg_write, reg_dst, mem_to_reg); end
    @(negedge clk);
    starts += int'(div_start);
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL div_return: got %0d want 1", state_o); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL div_start_pulses: got %0d want 1", starts); end
  endtask

  task automatic test_div_timeout();
    op = 6'b001001; funct = 6'b111111; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (state_o !== 4'd14 || div_timeout !== (k == 8) || reg_write !== 1'b0) begin
        errors++; $display("FAIL divto_wait[%0d]: state=%0d div_timeout=%b want 14 %0d", k, state_o, div_timeout, (k == 8)); end
    end
    @(negedge clk);
    checks++; if (state_o !== 4'd1 || reg_write !== 1'b0 || div_timeout !== 1'b0) begin
      errors++; $display("FAIL divto_return: state=%0d reg_write=%b want 1 0", state_o, reg_write); end
    div_done = 1'b1;
    @(negedge clk);
    div_done = 1'b0;
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL done_ignored: got %0d want 1", state_o); end
  endtask

  task automatic test_illegal();
    op = 6'b000000; funct = 6'b000111; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (state_o !== 4'd2 || illegal_op !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL illegal_decode: state=%0d illegal_op=%b want 2 1", state_o, illegal_op); end
    @(negedge clk);
    checks++; if (state_o !== 4'd1 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_return: state=%0d illegal_op=%b want 1 0", state_o, illegal_op); end
  endtask

  task automatic test_reset_midway();
    op = 6'b101011; funct = 6'd0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (state_o !== 4'd6 || mem_write !== 1'b1) begin
      errors++; $display("FAIL rst_pre: state=%0d mem_write=%b want 6 1", state_o, mem_write); end
    rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 4'd0 || strobes !== 16'd0 || alu_control !== 3'b010) begin
      errors++; $display("FAIL rst_async: state=%0d strobes=%h alu=%b want 0 0 010", state_o, strobes, alu_control); end
    @(negedge clk);
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rst_hold: got %0d want 0", state_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL rst_release: got %0d want 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_rtype();
    test_div_done();
    test_div_timeout();
    test_illegal();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
